multiword_add_seq: RTL

Word-serial multi-precision add/subtract controller. It time-multiplexes a single `prefix_adder_32` instance to add or subtract operands of 1 to 2^NW_BITS words, and chains the carry between words in a register. Operand words arrive least-significant word first on a valid/ready stream, and result words leave on a second valid/ready stream. The block sits between an operand source (e.g. a big-integer unit or DMA) and the shared adder datapath.

---
 rtl/multiword_add_seq.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/multiword_add_seq.sv
// Word-serial multi-precision add/subtract controller.
// A single 32-bit parallel-prefix adder is reused for every word. The carry
// between words is kept in carry_reg, and operands stream in least-significant
// word first. Results leave through a one-deep output register that passes
// straight through when downstream is ready, so throughput is one word per
// cycle.

// 32-bit Kogge-Stone adder: log2(32) = 5 prefix levels over (generate, propagate).
module prefix_adder_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] g_bit;
  logic [31:0] p_bit;
  logic [31:0] g_all;
  logic [31:0] p_all;
  logic [31:0] carry_vec;

  assign g_bit = a & b;
  assign p_bit = a ^ b;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : lvl
      localparam int SPAN = 1 << gi;
      // Bits below SPAN have no partner at this distance. Their group
      // propagate passes through unchanged, so the mask forces ones there.
      localparam logic [31:0] LOW_MASK = (32'd1 << SPAN) - 32'd1;
      logic [31:0] g_in;
      logic [31:0] p_in;
      logic [31:0] g_out;
      logic [31:0] p_out;
      if (gi == 0) begin : first
        assign g_in = g_bit;
        assign p_in = p_bit;
      end else begin : chain
        assign g_in = lvl[gi-1].g_out;
        assign p_in = lvl[gi-1].p_out;
      end
      assign g_out = g_in | (p_in & (g_in << SPAN));
      assign p_out = p_in & ((p_in << SPAN) | LOW_MASK);
    end
  endgenerate

  // After the last level, g_all[i]/p_all[i] span bits i..0. The carry into
  // bit i+1 then folds in cin.
  assign g_all     = lvl[4].g_out;
  assign p_all     = lvl[4].p_out;
  assign carry_vec = {g_all[30:0] | (p_all[30:0] & {31{cin}}), cin};
  assign sum       = p_bit ^ carry_vec;
  assign cout      = g_all[31] | (p_all[31] & cin);

endmodule

module multiword_add_seq #(
  parameter int WIDTH   = 32,  // tied to the shared adder, keep at 32
  parameter int NW_BITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               sub,
  input  logic [NW_BITS-1:0] nwords,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_s,
  output logic               out_last,
  output logic               done,
  output logic               carry_out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_reg;
  state_t             state_next;
  logic               sub_reg;
  logic [NW_BITS-1:0] nwords_reg;
  logic               carry_reg;
  // One bit wider than nwords so the count can pass nwords = all-ones.
  logic [NW_BITS:0]   word_cnt_reg;

  logic               start_fire;
  logic               in_fire;
  logic               out_fire;
  logic               all_in;
  logic               is_last_word;
  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH-1:0]   sum_w;
  logic               cout_w;

  assign start_fire   = (state_reg == IDLE) && start;
  assign in_fire      = in_valid && in_ready;
  assign out_fire     = out_valid && out_ready;
  assign all_in       = word_cnt_reg > {1'b0, nwords_reg};
  assign is_last_word = word_cnt_reg == {1'b0, nwords_reg};

  // Subtraction is A + ~B + 1. The +1 comes from carry_reg being preset to 1 at start.
  assign b_eff = sub_reg ? ~in_b : in_b;

  prefix_adder_32 u_adder (
    .a    (in_a),
    .b    (b_eff),
    .cin  (carry_reg),
    .sum  (sum_w),
    .cout (cout_w)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic and the outputs decoded from state.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    in_ready   = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy     = 1'b1;
        in_ready = !all_in && (!out_valid || out_ready);
        if (out_fire && out_last) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operation parameters are captured once, when start is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sub_reg    <= 1'b0;
      nwords_reg <= '0;
    end else if (start_fire) begin
      sub_reg    <= sub;
      nwords_reg <= nwords;
    end
  end

  // Inter-word carry and word counter. Both advance once per accepted operand pair.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carry_reg    <= 1'b0;
      word_cnt_reg <= '0;
    end else if (start_fire) begin
      carry_reg    <= sub;
      word_cnt_reg <= '0;
    end else if (in_fire) begin
      carry_reg    <= cout_w;
      word_cnt_reg <= word_cnt_reg + 1'b1;
    end
  end

  // Output register. A new word overwrites it on input handshake; otherwise
  // a consumed word empties it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_s     <= '0;
      out_last  <= 1'b0;
    end else if (in_fire) begin
      out_valid <= 1'b1;
      out_s     <= sum_w;
      out_last  <= is_last_word;
    end else if (out_fire) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  // The final carry is published when the top word leaves and is held until the next start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carry_out <= 1'b0;
    end else if (start_fire) begin
      carry_out <= 1'b0;
    end else if (out_fire && out_last) begin
      carry_out <= carry_reg;
    end
  end

endmodule
